// File: rtl/rom_arbiter.sv
// Arbitrates NREQ requesters onto one registered-read ROM; responses return 2 cycles after grant.
// Define ROM_ARB_RR_EN for round-robin arbitration; fixed priority (lowest index) otherwise.
module rom_arbiter #(
   parameter int NREQ  = 4,
   parameter int ADDRW = 9,
   parameter int WIDTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [NREQ-1:0]       i_req_valid,
   input  logic [NREQ*ADDRW-1:0] i_req_addr,
   output logic [NREQ-1:0]       o_req_ready,
   output logic [NREQ-1:0]       o_rsp_valid,
   output logic [WIDTH-1:0]      o_rsp_data,
   output logic [ADDRW-1:0]      o_rom_addr,
   input  logic [WIDTH-1:0]      i_rom_data
);

   localparam int PW = $clog2(NREQ);

   logic [NREQ-1:0]  w_grant;
   logic             w_found;
   logic [PW:0]      w_sum;
   logic [ADDRW-1:0] w_addr;
   logic [ADDRW-1:0] r_rom_addr;
   logic [NREQ-1:0]  r_s1;
   logic [NREQ-1:0]  r_s2;

`ifdef ROM_ARB_RR_EN
   localparam logic [PW:0]   NREQ_W = (PW+1)'(NREQ);
   localparam logic [PW-1:0] LAST   = PW'(NREQ-1);
   logic [PW-1:0] r_ptr;
   logic [PW-1:0] w_gidx;
`endif

   // Priority search: starts at r_ptr in round-robin mode, at index 0 otherwise.
   always_comb begin
      w_grant = '0;
      w_found = 1'b0;
      w_sum   = '0;
`ifdef ROM_ARB_RR_EN
      w_gidx  = '0;
`endif
      for (int k = 0; k < NREQ; k++) begin
`ifdef ROM_ARB_RR_EN
         w_sum = {1'b0, r_ptr} + (PW+1)'(k);
         if (w_sum >= NREQ_W) w_sum = w_sum - NREQ_W;
`else
         w_sum = (PW+1)'(k);
`endif
         if (!w_found && i_req_valid[w_sum[PW-1:0]]) begin
            w_found                   = 1'b1;
            w_grant[w_sum[PW-1:0]]    = 1'b1;
`ifdef ROM_ARB_RR_EN
            w_gidx                    = w_sum[PW-1:0];
`endif
         end
      end
   end

   always_comb begin
      w_addr = '0;
      for (int i = 0; i < NREQ; i++)
         if (w_grant[i]) w_addr = i_req_addr[i*ADDRW +: ADDRW];
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rom_addr <= '0;
         r_s1       <= '0;
         r_s2       <= '0;
      end else begin
         r_s1 <= w_grant;
         r_s2 <= r_s1;
         // Address holds when idle so the ROM input does not toggle.
         if (w_found) r_rom_addr <= w_addr;
      end
   end

`ifdef ROM_ARB_RR_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_ptr <= '0;
      else if (w_found)
         r_ptr <= (w_gidx == LAST) ? '0 : w_gidx + 1'b1;
   end
`endif

   assign o_req_ready = w_grant;
   assign o_rsp_valid = r_s2;
   assign o_rsp_data  = i_rom_data;
   assign o_rom_addr  = r_rom_addr;

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Shares one `rom_sync` instance (1-cycle registered read) among NREQ requesters, such as tile fetch, sprite fetch and palette lookup. Uses valid/ready request handshakes and round-robin or fixed-priority arbitration. Registers the ROM address, tracks in-flight reads in a 2-stage grant pipeline, and routes each returned word to its requester with a one-hot response strobe. Sits between the PPU fetch engines and the ROM; one request is accepted per cycle at full throughput.

## Interface
- NREQ, 4: number of requesters, 2..8.
- ADDRW, 9: ROM address width; must equal the ROM's ADDRW.
- WIDTH, 8: ROM data width.

- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request strobe.
- req_addr  in  NREQ*ADDRW  packed addresses; requester i at [i*ADDRW +: ADDRW].
- req_ready  out  NREQ  one-hot-or-zero grant; combinational from req_valid and arbiter state.
- rsp_valid  out  NREQ  one-hot-or-zero response strobe, registered.
- rsp_data  out  WIDTH  response word; equals rom_data, valid only while some rsp_valid bit is set.
- rom_addr  out  ADDRW  registered address to `rom_sync.addr`.
- rom_data  in  WIDTH  from `rom_sync.data`.

## Operation
- Arbitration is combinational each cycle over req_valid.
  - At most one req_ready bit is high.
  - req_ready[i] is never high without req_valid[i].
  - Any nonzero req_valid produces exactly one grant; there are no idle cycles.
- Handshake: a request is accepted in any cycle with req_valid[i] & req_ready[i].
  - A requester holds req_valid and req_addr stable until accepted.
  - A requester may change req_addr only after acceptance.
- On acceptance, rom_addr <= req_addr[i] and grant stage s1 <= onehot(i).
- With no acceptance:
  - rom_addr holds its previous value (no address toggling).
  - s1 <= 0.
- Every edge: s2 <= s1. rsp_valid = s2 (registered).
- Responses return in acceptance order, one per accepted request, with no loss and no duplication.
- Responses have no back-pressure. A requester must consume rsp_data in the cycle its rsp_valid bit is high.
- Round-robin state: ptr (clog2(NREQ) bits).
  - Search order is ptr, ptr+1, …, NREQ-1, 0, …, ptr-1.
  - After a grant to i, ptr <= (i+1) mod NREQ. Wrap from NREQ-1 goes to 0.
  - With no grant, ptr holds.
- Reset values (asynchronous, immediate): rom_addr=0, s1=0, s2=0, rsp_valid=0, ptr=0.
  - req_ready follows req_valid combinationally even during reset.
  - Requests accepted while rst_n=0 are discarded.
- Reset mid-operation: all in-flight reads are dropped and no rsp_valid fires for them. After release, arbitration starts from ptr=0.

## Timing
- Acceptance in cycle N.
  - rom_addr updates at edge N (end of cycle N) and is valid in cycle N+1.
  - The ROM captures the address at edge N+1. rom_data and rsp_valid[i] are valid in cycle N+2.
- Latency from acceptance to response: 2 cycles. Throughput: 1 request per cycle.
- Back-to-back acceptances to different requesters in cycles N and N+1 produce responses in cycles N+2 and N+3, each with only the matching bit set.
- Combinational path: req_valid -> req_ready, through a NREQ-wide priority search. There is no combinational path from req_valid to rom_addr or rsp_*.

## Configuration
- Macro: ROM_ARB_RR_EN.
- Defined: round-robin arbitration as above. ptr is instantiated.
- Undefined: fixed priority, where the lowest index with req_valid wins. ptr is not instantiated. Handshake, pipeline, latency and reset behaviour are identical.

## Test plan
- Single request: req_valid=4'b0001, addr 0x055 held until accepted, ROM word 0x055 = 0xA7. Expect req_ready=0001 the same cycle, rom_addr=0x055 in N+1, rsp_valid=0001 and rsp_data=0xA7 in N+2, rsp_valid=0 in N+3.
- Round-robin fairness (RR_EN): all four valid continuously from reset. Expect grants 0,1,2,3,0,1… one per cycle and responses in the same order, 2 cycles later, with correct data.
- Fixed priority (no RR_EN): req_valid=1111 for 3 cycles, then 1110. Expect grants 0,0,0,1.
- Wrap and skip (RR_EN): after a grant to 3, valid=0110. Expect grant 1, then 2, then 1.
- Idle hold: accept addr 0x1FF, then req_valid=0 for 5 cycles. Expect rom_addr to stay 0x1FF and exactly one rsp_valid pulse.
- Reset mid-flight: accept requests in cycles N and N+1, assert rst_n=0 in cycle N+1. Expect rsp_valid=0 immediately and no responses after release. The first post-reset grant goes to the lowest valid index.
